// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// Imported by the round-robin picker and the arbiter top.
package uart_arb_pkg;

    localparam int ARB_NREQ         = 4;
    localparam int ARB_BUSY_TIMEOUT = 15;
    localparam int ARB_BYTE_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// searching upward modulo NREQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NREQ = ARB_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [NREQ-1:0] w_rot;
    logic [IW:0]     w_sum;

    // Doubling the vector makes the wrap-around a plain shift.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        valid = 1'b0;
        w_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid = 1'b1;
                w_sum = {1'b0, ptr} + (IW + 1)'(k);
            end
        end
        if (w_sum >= (IW + 1)'(NREQ)) begin
            w_sum = w_sum - (IW + 1)'(NREQ);
        end
        winner = w_sum[IW-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters,
// with a watchdog on the transmitter's busy response.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ         = ARB_NREQ,
    parameter  int BUSY_TIMEOUT = ARB_BUSY_TIMEOUT,
    localparam int IW           = $clog2(NREQ),
    localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [ARB_BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]            grant,
    output logic                       tx_start,
    output logic [ARB_BYTE_W-1:0]      tx_data,
    input  logic                       tx_busy,
    output logic [IW-1:0]              owner,
    output logic                       timeout_err
);

    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    arb_state_t            r_state;
    logic [IW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;
    logic [NREQ-1:0]       r_grant;
    logic                  r_tx_start;
    logic [ARB_BYTE_W-1:0] r_tx_data;
    logic [IW-1:0]         r_owner;
    logic                  r_timeout_err;

    logic [IW-1:0]         w_winner;
    logic                  w_valid;
    logic [ARB_BYTE_W-1:0] w_byte;
    logic [NREQ-1:0]       w_onehot;
    logic [IW-1:0]         w_ptr_nxt;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_comb begin
        w_byte   = '0;
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IW'(i)) begin
                w_byte      = req_data[i*ARB_BYTE_W +: ARB_BYTE_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_winner == IW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_owner       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!tx_busy && w_valid) begin
                        r_grant   <= w_onehot;
                        r_owner   <= w_winner;
                        r_tx_data <= w_byte;
                        r_ptr     <= w_ptr_nxt;
                        r_state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_tx_start <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        // Transmitter never answered: drop the byte, no retry.
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a model
// transmitter and a round-robin reference model predicting grant order.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] grant;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic [1:0]   owner;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bq_t  rq[N];
    bq_t  mq[N];
    int   mptr = 0;
    exp_t exp_q[$];
    exp_t cur;

    bit start_pending = 0;
    bit frame_active  = 0;
    int grant_cyc = 0;
    int n_grant   = 0;
    int n_start   = 0;
    int n_to      = 0;
    int to_done   = 0;

    bit xt_busy    = 0;
    bit force_busy = 0;
    bit rand_drop  = 0;
    bit frame_rand = 0;
    int frame_len  = 100;
    int xt_state   = 0;
    int xt_cnt     = 0;
    int drop_req   = 0;
    int drop_used  = 0;
    int to_issued  = 0;
    int to_start_cyc = 0;

    assign tx_busy = xt_busy | force_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NREQ         (N),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic load(input int i, input logic [7:0] b);
        rq[i].push_back(b);
        mq[i].push_back(b);
    endtask

    // Reference: repeatedly pick the first non-empty requester from mptr.
    task automatic predict();
        bit   found;
        int   i;
        exp_t e;
        do begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                i = (mptr + k) % N;
                if (!found && mq[i].size() > 0) begin
                    e.idx  = i;
                    e.data = mq[i].pop_front();
                    exp_q.push_back(e);
                    mptr  = (i + 1) % N;
                    found = 1;
                end
            end
        end while (found);
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (t < budget && !(exp_q.size() == 0 && !start_pending &&
               xt_state == 0 && to_issued == to_done && !tx_busy)) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("drain_in_budget", int'(t < budget), 1);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) chk("rq_empty", rq[i].size(), 0);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            start_pending = 0;
            frame_active  = 0;
            to_done       = to_issued;
        end else begin
            if (grant != '0) begin
                chk("grant_onehot", int'($onehot(grant)), 1);
                chk("grant_alone", int'(tx_start | timeout_err), 0);
                if (exp_q.size() == 0) begin
                    chk("grant_expected", int'(grant), 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_idx", int'(grant), 1 << cur.idx);
                    chk("grant_owner", int'(owner), cur.idx);
                    chk("grant_data", int'(tx_data), int'(cur.data));
                    frame_active  = 1;
                    start_pending = 1;
                    grant_cyc     = cyc;
                    n_grant++;
                end
            end else if (frame_active) begin
                chk("owner_stable", int'(owner), cur.idx);
                chk("data_stable", int'(tx_data), int'(cur.data));
            end
            if (tx_start) begin
                chk("start_alone", int'(timeout_err), 0);
                chk("start_after_grant", int'(start_pending), 1);
                chk("start_latency", cyc - grant_cyc, 1);
                start_pending = 0;
                n_start++;
            end
            if (timeout_err) begin
                chk("timeout_expected", to_issued - to_done, 1);
                chk("timeout_delay", cyc - to_start_cyc, TMO);
                to_done = to_issued;
                n_to++;
            end else if (to_issued != to_done && cyc - to_start_cyc > TMO) begin
                chk("timeout_missing", int'(timeout_err), 1);
                to_done = to_issued;
            end
        end
    end

    // Requesters and model transmitter.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst && grant[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            req[i] = (rq[i].size() > 0);
            req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
        if (rst) begin
            xt_busy  = 0;
            xt_state = 0;
            xt_cnt   = 0;
        end else begin
            case (xt_state)
                0: if (tx_start) begin
                    if (drop_used < drop_req || (rand_drop && $urandom_range(0, 3) == 0)) begin
                        if (drop_used < drop_req) drop_used++;
                        to_start_cyc = cyc;
                        to_issued++;
                    end else begin
                        xt_state = 1;
                        xt_cnt   = 2;
                    end
                end
                1: begin
                    xt_cnt--;
                    if (xt_cnt == 0) begin
                        xt_busy  = 1;
                        xt_state = 2;
                        xt_cnt   = frame_rand ? int'($urandom_range(2, 10)) : frame_len;
                    end
                end
                default: begin
                    xt_cnt--;
                    if (xt_cnt == 0) begin
                        xt_busy  = 0;
                        xt_state = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, s0, t0, t;
        #23;
        chk("rst_grant", int'(grant), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        @(negedge clk);
        #1 rst = 0;

        // Single requester, long frame, exact latency.
        @(posedge clk);
        #2;
        frame_rand = 0;
        frame_len  = 100;
        g0 = n_grant;
        s0 = n_start;
        load(2, 8'hA5);
        predict();
        @(negedge clk);
        #1 chk("req_raised", int'(req), 4'b0100);
        @(posedge clk);
        #1;
        chk("a5_grant", int'(grant), 4'b0100);
        chk("a5_owner", int'(owner), 2);
        chk("a5_data", int'(tx_data), 8'hA5);
        chk("a5_start_early", int'(tx_start), 0);
        @(posedge clk);
        #1;
        chk("a5_start", int'(tx_start), 1);
        chk("a5_grant_drop", int'(grant), 0);
        wait_done(400);
        chk("a5_grants", n_grant - g0, 1);
        chk("a5_starts", n_start - s0, 1);
        chk("a5_owner_hold", int'(owner), 2);

        // ptr=3 after serving 2: requester 3 then 0.
        frame_rand = 1;
        load(0, 8'h11);
        load(3, 8'h33);
        predict();
        wait_done(400);

        // Transmitter never goes busy.
        t0 = n_to;
        drop_req++;
        load(1, 8'($urandom));
        predict();
        wait_done(400);
        chk("to_count", n_to - t0, 1);
        load(2, 8'($urandom));
        predict();
        wait_done(400);
        chk("to_after_count", n_to - t0, 1);

        // Busy held in IDLE blocks grants.
        force_busy = 1;
        load(0, 8'h5A);
        predict();
        repeat (8) begin
            @(posedge clk);
            #1 chk("busy_no_grant", int'(grant), 0);
        end
        @(negedge clk);
        force_busy = 0;
        @(posedge clk);
        #1 chk("busy_release_grant", int'(grant), 4'b0001);
        wait_done(400);

        // Reset during WAIT_DONE; restart from requester 0.
        frame_rand = 0;
        frame_len  = 30;
        load(2, 8'h3C);
        predict();
        t = 0;
        while (!tx_busy && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        chk("rst_busy_seen", int'(tx_busy), 1);
        load(3, 8'hC3);
        load(1, 8'h96);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_tx_start", int'(tx_start), 0);
        chk("mid_rst_timeout", int'(timeout_err), 0);
        chk("mid_rst_owner", int'(owner), 0);
        chk("mid_rst_tx_data", int'(tx_data), 0);
        mptr = 0;
        predict();
        @(negedge clk);
        #1 rst = 0;
        wait_done(400);

        // All four held: 0,1,2,3,0.
        frame_rand = 1;
        load(0, 8'hA0);
        load(0, 8'hA4);
        load(1, 8'hA1);
        load(2, 8'hA2);
        load(3, 8'hA3);
        predict();
        wait_done(600);

        // Randomized rounds with random drops.
        rand_drop = 1;
        repeat (5) begin
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 3)) load(i, 8'($urandom));
            end
            predict();
            wait_done(3000);
        end
        rand_drop = 0;
        chk("starts_eq_grants", n_start, n_grant);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
